// File: rtl/count_cycle_frame_if.sv
// Stream bundle for count_cycle_frame: s_axis beats in, tagged m_axis beats out.
// With COUNT_CYCLE_FRAME_TRUNC_EN defined the bundle also carries m_axis_trunc.
interface count_cycle_frame_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned FRAME_WIDTH = 8
);
  logic                   s_axis_tvalid;
  logic [DATA_WIDTH-1:0]  s_axis_tdata;
  logic                   s_axis_tready;
  logic                   m_axis_tvalid;
  logic [DATA_WIDTH-1:0]  m_axis_tdata;
  logic                   m_axis_tlast;
  logic [CNT_WIDTH-1:0]   m_axis_count;
  logic [FRAME_WIDTH-1:0] m_axis_frame;
  logic                   m_axis_tready;
`ifdef COUNT_CYCLE_FRAME_TRUNC_EN
  logic                   m_axis_trunc;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_count,
           m_axis_frame, m_axis_trunc
  );
  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_count,
           m_axis_frame, m_axis_trunc
  );
`else
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_count,
           m_axis_frame
  );
  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_count,
           m_axis_frame
  );
`endif
endinterface

// File: rtl/count_cycle_frame.sv
// Tags accepted stream beats with in-frame count, final flag and frame index, then buffers them
// in a FIFO with almost-full backpressure. COUNT_CYCLE_FRAME_TRUNC_EN adds the truncation tag.
module count_cycle_frame #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned FRAME_WIDTH     = 8,
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CNT_WIDTH-1:0] cnt_limit,
  input  logic                 start_sig,
  count_cycle_frame_if.slave   bus
);
  localparam int unsigned Depth = 1 << FIFO_ADDR_WIDTH;
  // Three slots of headroom: two beats in the tag pipeline plus the registered-ready lag.
  localparam logic [FIFO_ADDR_WIDTH:0] AfLevel = (FIFO_ADDR_WIDTH + 1)'(Depth - 3);

  typedef struct packed {
`ifdef COUNT_CYCLE_FRAME_TRUNC_EN
    logic                   trunc;
`endif
    logic                   last;
    logic [FRAME_WIDTH-1:0] frame;
    logic [CNT_WIDTH-1:0]   count;
    logic [DATA_WIDTH-1:0]  data;
  } beat_t;

  logic                   first_q, prev_final_q, tready_q;
  logic [CNT_WIDTH-1:0]   cnt_q, limit_q;
  logic [FRAME_WIDTH-1:0] frame_q;

  logic                   take, restart;
  logic [CNT_WIDTH-1:0]   cnt_d, limit_d;
  logic [FRAME_WIDTH-1:0] frame_d;
  beat_t                  beat_d;

  assign take = bus.s_axis_tvalid & tready_q;

  always_comb begin
    restart = first_q | start_sig | prev_final_q;
    cnt_d   = restart ? '0 : cnt_q + CNT_WIDTH'(1);
    limit_d = restart ? cnt_limit : limit_q;
    if (first_q) begin
      frame_d = '0;
    end else if (restart) begin
      frame_d = frame_q + FRAME_WIDTH'(1);
    end else begin
      frame_d = frame_q;
    end
    beat_d       = '0;
    beat_d.data  = bus.s_axis_tdata;
    beat_d.count = cnt_d;
    beat_d.frame = frame_d;
    beat_d.last  = (cnt_d == limit_d);
`ifdef COUNT_CYCLE_FRAME_TRUNC_EN
    beat_d.trunc = start_sig & ~first_q & ~prev_final_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_q      <= 1'b1;
      prev_final_q <= 1'b0;
      cnt_q        <= '0;
      limit_q      <= '0;
      frame_q      <= '0;
    end else if (take) begin
      first_q      <= 1'b0;
      prev_final_q <= beat_d.last;
      cnt_q        <= cnt_d;
      limit_q      <= limit_d;
      frame_q      <= frame_d;
    end
  end

  // Two register stages give the fixed take-to-write latency.
  beat_t s1_q, s2_q;
  logic  s1_valid_q, s2_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= take;
      s2_valid_q <= s1_valid_q;
      if (take) begin
        s1_q <= beat_d;
      end
      s2_q <= s1_q;
    end
  end

  beat_t                    mem_q [Depth];
  logic [FIFO_ADDR_WIDTH:0] wr_ptr_q, rd_ptr_q, occ;
  logic                     empty, pop;
  beat_t                    rd_beat;

  assign occ     = wr_ptr_q - rd_ptr_q;
  assign empty   = (occ == '0);
  assign pop     = ~empty & bus.m_axis_tready;
  assign rd_beat = mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (s2_valid_q) begin
      mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tready_q <= 1'b0;
    end else begin
      if (s2_valid_q) begin
        wr_ptr_q <= wr_ptr_q + (FIFO_ADDR_WIDTH + 1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (FIFO_ADDR_WIDTH + 1)'(1);
      end
      tready_q <= (occ < AfLevel);
    end
  end

  // Tag fields read as zero whenever nothing is presented (including during reset).
  assign bus.s_axis_tready = tready_q;
  assign bus.m_axis_tvalid = ~empty;
  assign bus.m_axis_tdata  = rd_beat.data;
  assign bus.m_axis_tlast  = ~empty & rd_beat.last;
  assign bus.m_axis_count  = empty ? '0 : rd_beat.count;
  assign bus.m_axis_frame  = empty ? '0 : rd_beat.frame;
`ifdef COUNT_CYCLE_FRAME_TRUNC_EN
  assign bus.m_axis_trunc  = ~empty & rd_beat.trunc;
`endif

endmodule

// File: tb/tb_count_cycle_frame.sv
// Randomized and directed bench for count_cycle_frame against a queue-based tagging model.
// Honours COUNT_CYCLE_FRAME_TRUNC_EN for the optional truncation tag.
module tb_count_cycle_frame;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 16;
  localparam int unsigned FW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  localparam int S3_CNT [5] = '{0, 1, 0, 1, 2};
  localparam int S3_FRM [5] = '{0, 0, 1, 1, 1};
  localparam int S4_CNT [8] = '{0, 1, 2, 3, 4, 0, 1, 2};

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [CW-1:0] cnt_limit;
  logic          start_sig;

  count_cycle_frame_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .FRAME_WIDTH(FW)) bus ();

  count_cycle_frame #(
    .DATA_WIDTH      (DW),
    .CNT_WIDTH       (CW),
    .FRAME_WIDTH     (FW),
    .FIFO_ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cnt_limit (cnt_limit),
    .start_sig (start_sig),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   count;
    int unsigned   frame;
    bit            last;
    bit            trunc;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          first_take_cyc = -1;
  int          first_out_cyc = -1;
  int unsigned m_taken, m_cnt, m_lim, m_frame;
  bit          m_prev_final;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_beat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Tagging rules applied to each accepted beat, in acceptance order.
  task automatic model_take();
    beat_t b;
    bit    restart;
    restart = (m_taken == 0) || start_sig || m_prev_final;
    b.trunc = start_sig && (m_taken != 0) && !m_prev_final;
    if (restart) begin
      m_frame = (m_taken == 0) ? 0 : (m_frame + 1) % (1 << FW);
      m_cnt   = 0;
      m_lim   = cnt_limit;
    end else begin
      m_cnt++;
    end
    b.data       = bus.s_axis_tdata;
    b.count      = m_cnt;
    b.frame      = m_frame;
    b.last       = (m_cnt == m_lim);
    m_prev_final = b.last;
    m_taken++;
    if (first_take_cyc < 0) first_take_cyc = cyc;
    exp_q.push_back(b);
  endtask

  task automatic compare_out();
    beat_t o, e;
    o.data  = bus.m_axis_tdata;
    o.count = bus.m_axis_count;
    o.frame = bus.m_axis_frame;
    o.last  = bus.m_axis_tlast;
`ifdef COUNT_CYCLE_FRAME_TRUNC_EN
    o.trunc = bus.m_axis_trunc;
`else
    o.trunc = 1'b0;
`endif
    obs_q.push_back(o);
    if (exp_q.size() == 0) begin
      check_eq("out_unexpected", bus.m_axis_tvalid, 0);
    end else begin
      e = exp_q.pop_front();
      check_eq("out_data", o.data, e.data);
      check_eq("out_count", o.count, e.count);
      check_eq("out_frame", o.frame, e.frame);
      check_eq("out_last", o.last, e.last);
`ifdef COUNT_CYCLE_FRAME_TRUNC_EN
      check_eq("out_trunc", o.trunc, e.trunc);
`endif
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", bus.m_axis_tvalid, 1);
        check_eq("hold_beat", {bus.m_axis_tdata, bus.m_axis_count, bus.m_axis_frame,
                               bus.m_axis_tlast}, prev_beat);
      end
      if (bus.s_axis_tvalid && bus.s_axis_tready) model_take();
      if (bus.m_axis_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
      if (bus.m_axis_tvalid && bus.m_axis_tready) compare_out();
      if (exp_q.size() > DEPTH + 2) check_eq("overflow", exp_q.size(), DEPTH + 2);
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_beat  = {bus.m_axis_tdata, bus.m_axis_count, bus.m_axis_frame, bus.m_axis_tlast};
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    start_sig = 1'b0;
    exp_q.delete();
    obs_q.delete();
    m_taken = 0; m_cnt = 0; m_lim = 0; m_frame = 0; m_prev_final = 1'b0;
    first_take_cyc = -1;
    first_out_cyc = -1;
    #1;
    check_eq("rst_m_tvalid", bus.m_axis_tvalid, 0);
    check_eq("rst_s_tready", bus.s_axis_tready, 0);
    check_eq("rst_m_tlast", bus.m_axis_tlast, 0);
    check_eq("rst_m_count", bus.m_axis_count, 0);
    check_eq("rst_m_frame", bus.m_axis_frame, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rel_tready_pre", bus.s_axis_tready, 0);
    @(posedge clk);
    #1;
    check_eq("rel_tready_post", bus.s_axis_tready, 1);
  endtask

  task automatic send_beat(input logic st);
    int guard = 0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = $urandom;
    start_sig = st;
    @(negedge clk);
    while (!bus.s_axis_tready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("send_ready", bus.s_axis_tready, 1);
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    start_sig = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || bus.m_axis_tvalid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string tag, input int i, input int cnt, input int frm,
                           input bit last);
    if (i >= obs_q.size()) begin
      check_eq({tag, "_missing"}, obs_q.size(), i + 1);
    end else begin
      check_eq({tag, "_count"}, obs_q[i].count, cnt);
      check_eq({tag, "_frame"}, obs_q[i].frame, frm);
      check_eq({tag, "_last"}, obs_q[i].last, last);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit tk;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b1;
    start_sig = 1'b0;
    cnt_limit = 3;
    #2;

    // Frames of four beats, plus first-beat latency.
    do_reset();
    for (int i = 0; i < 10; i++) send_beat(1'b0);
    wait_drain();
    check_eq("s1_latency", first_out_cyc - first_take_cyc, 3);
    for (int i = 0; i < 10; i++) check_obs("s1", i, i % 4, i / 4, (i % 4) == 3);

    // Single-beat frames.
    cnt_limit = 0;
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(1'b0);
    wait_drain();
    for (int i = 0; i < 4; i++) check_obs("s2", i, 0, i, 1'b1);

    // Mid-frame restart.
    cnt_limit = 7;
    do_reset();
    for (int i = 0; i < 5; i++) send_beat(i == 2);
    wait_drain();
    for (int i = 0; i < 5; i++) check_obs("s3", i, S3_CNT[i], S3_FRM[i], 1'b0);
`ifdef COUNT_CYCLE_FRAME_TRUNC_EN
    for (int i = 0; i < 5 && i < obs_q.size(); i++) check_eq("s3_trunc", obs_q[i].trunc, i == 2);
`endif

    // Limit change mid-frame applies to the next frame only.
    cnt_limit = 4;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) cnt_limit = 2;
      send_beat(1'b0);
    end
    wait_drain();
    for (int i = 0; i < 8; i++) check_obs("s4", i, S4_CNT[i], (i < 5) ? 0 : 1, i == 4 || i == 7);

    // Backpressure fill: exactly DEPTH beats accepted, none lost.
    cnt_limit = 5;
    do_reset();
    bus.m_axis_tready = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = $urandom;
    repeat (40) begin
      @(negedge clk);
      tk = bus.s_axis_tready;
      @(posedge clk);
      #1;
      if (tk) bus.s_axis_tdata = $urandom;
    end
    check_eq("s5_stored", m_taken, DEPTH);
    check_eq("s5_tready", bus.s_axis_tready, 0);
    check_eq("s5_tvalid", bus.m_axis_tvalid, 1);
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    wait_drain();
    check_eq("s5_emerged", obs_q.size(), DEPTH);

    // Reset while the FIFO holds buffered beats.
    cnt_limit = 9;
    do_reset();
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("s6_held", bus.m_axis_tvalid, 1);
    do_reset();
    bus.m_axis_tready = 1'b1;
    send_beat(1'b0);
    wait_drain();
    check_eq("s6_nbeats", obs_q.size(), 1);
    check_obs("s6", 0, 0, 0, 1'b0);

    // Randomized traffic with changing limits, restarts and output stalls.
    cnt_limit = 2;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.s_axis_tvalid = ($urandom_range(0, 3) != 0);
      bus.s_axis_tdata  = $urandom;
      start_sig = ($urandom_range(0, 15) == 0);
      if (((i / 200) % 2) == 1) bus.m_axis_tready = ($urandom_range(0, 3) == 0);
      else bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) cnt_limit = CW'($urandom_range(0, 6));
      @(posedge clk);
      #1;
    end
    bus.s_axis_tvalid = 1'b0;
    start_sig = 1'b0;
    bus.m_axis_tready = 1'b1;
    wait_drain();
    check_eq("rnd_all_out", obs_q.size(), m_taken);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_cycle_frame.md
Name: count_cycle_frame

Overview:
Parametrised successor to the fixed 16-bit count/align block. Tags every accepted AXI-Stream beat with:
- an in-frame count (CNT_WIDTH bits);
- a final-beat flag (tlast);
- a wrapping frame index.

Tagged beats are buffered in an internal FIFO with almost-full backpressure. It sits between sample sources and metadata-consuming stages (channelizer framing, packetizers). New relative to the predecessor: configurable widths and depth, a per-frame latched limit, and a frame index.

Parameters:
DATA_WIDTH, 32, payload width in bits.
CNT_WIDTH, 16, width of in-frame count and cnt_limit (min 2, max 32).
FRAME_WIDTH, 8, width of frame index counter (min 1).
FIFO_ADDR_WIDTH, 4, FIFO depth = 2**FIFO_ADDR_WIDTH entries (min 3).

Ports:
clk  in  1  single clock; all logic rising-edge.
reset_n  in  1  asynchronous active-low reset; assertion async, deassertion synchronous to clk (guaranteed externally).
s_axis_tvalid  in  1  input beat valid.
s_axis_tdata  in  DATA_WIDTH  input payload.
s_axis_tready  out  1  = ~almost_full; 0 while reset_n low.
cnt_limit  in  CNT_WIDTH  final count of a frame (frame length = cnt_limit+1).
start_sig  in  1  force the accepted beat in this cycle to count 0 (new frame).
m_axis_tvalid  out  1  output beat valid.
m_axis_tdata  out  DATA_WIDTH  payload, order-preserved.
m_axis_tlast  out  1  beat count == latched limit.
m_axis_count  out  CNT_WIDTH  in-frame count of the beat.
m_axis_frame  out  FRAME_WIDTH  frame index of the beat.
m_axis_tready  in  1  downstream ready.

Behaviour:
Acceptance:
- take = s_axis_tvalid & s_axis_tready.
- Only taken beats advance counters and enter the pipeline.

Counting:
- A taken beat gets count 0 if any of these hold: it is the first beat after reset; start_sig=1; the previous taken beat was final. Otherwise it gets previous count + 1.
- On each count-0 beat, cnt_limit is sampled into limit_q. Changes to cnt_limit mid-frame take effect next frame only.
- final = (count == limit_q), compared against the limit latched for that beat's frame. cnt_limit=0 makes every beat final with count 0.
- count never exceeds limit_q, so it cannot wrap inside CNT_WIDTH.

Frame index:
- 0 for the first frame after reset.
- Increments by 1 (mod 2**FRAME_WIDTH) on every later count-0 beat, including start_sig restarts.

Simultaneous events: start_sig on a beat that would have been count 0 anyway restarts once. There is no double increment and no skipped frame index.

Truncation: start_sig mid-frame ends the old frame with no tlast beat. That is legal; see the optional feature.

Pipeline:
- Count/compare logic may be split (e.g. 8-bit slices with carry register) to meet timing. Externally, latency is fixed.
- A beat taken at cycle N is written to the FIFO at cycle N+2. With FIFO empty and m_axis_tready=1, it appears on m_axis at cycle N+3.

FIFO:
- Stores {trunc (if enabled), final, frame, count, data}.
- AXI handshake on m_axis: tvalid held until tready; data stable while tvalid & ~tready.
- almost_full = occupancy >= DEPTH-3, covering 2 in-flight beats plus 1 margin. The FIFO never overflows; a write when full is a design error (assertion in bench).
- Full throughput: 1 beat/clk sustained when m_axis_tready=1.

Reset (async, any time, including mid-frame):
- Counters, limit_q, frame index, pipeline valids and FIFO pointers clear.
- m_axis_tvalid=0, s_axis_tready=0, m_axis_tlast=0, m_axis_count=0, m_axis_frame=0.
- In-flight and buffered beats are discarded.
- s_axis_tready=1 on the first clk edge after deassertion.

Optional Feature:
Macro COUNT_CYCLE_FRAME_TRUNC_EN.
- Defined: adds output m_axis_trunc (1 bit), carried through the FIFO alongside the beat. It is 1 on a count-0 beat caused by start_sig when the previous taken beat was not final and at least one beat has been taken since reset; otherwise 0. Reset value 0.
- Undefined: port and FIFO bit are absent; behaviour otherwise identical.

Test Plan:
- Reset, cnt_limit=3, continuous tvalid, tready=1, 10 beats -> counts 0,1,2,3,0,1,2,3,0,1; tlast on beats 4 and 8; frame 0,0,0,0,1,1,1,1,2,2; first m_axis_tvalid at take+3 cycles.
- cnt_limit=0, 4 beats -> all counts 0, all tlast=1, frames 0,1,2,3.
- cnt_limit=7, start_sig on 3rd beat -> counts 0,1,0,1..; frame 0,0,1,..; no tlast before restart; trunc=1 on 3rd beat if COUNT_CYCLE_FRAME_TRUNC_EN.
- cnt_limit changed 4->2 at beat 2 of frame -> current frame still ends at count 4; next frame ends at count 2.
- m_axis_tready=0, FIFO_ADDR_WIDTH=4, continuous input -> s_axis_tready drops at occupancy 13; exactly 16 beats stored, no loss; release tready -> all 16 beats emerge in order, correct tags.
- reset_n pulsed low mid-frame with FIFO holding 5 beats -> m_axis_tvalid=0 immediately; after release, the next beat has count 0 and frame 0.
